// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with a single-line refill engine.
// Lookup is combinational; a miss refills a whole line over a req/valid handshake.
module icache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        invalidate,
    output logic [31:0] instr,
    output logic        ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int W  = $clog2(WORDS);
    localparam int L  = $clog2(LINES);
    localparam int TW = 32 - W - L - 2;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [W-1:0] LAST_WORD = W'(WORDS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LINES-1:0]  r_valid;
    logic [TW-1:0]     r_tag  [LINES];
    logic [31:0]       r_data [LINES][WORDS];
    logic              r_pend_inv;
    logic [31:0]       r_mem_addr;
    logic [W-1:0]      r_word_cnt;
    logic [31:0]       r_hit_cnt;
    logic [31:0]       r_miss_cnt;

    logic [L-1:0]      w_idx;
    logic [W-1:0]      w_off;
    logic [TW-1:0]     w_tag;
    logic [L-1:0]      w_ridx;
    logic [TW-1:0]     w_rtag;
    logic [31:0]       w_base;
    logic              w_hit;
    logic              w_last;
    logic              w_unused_pc;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign w_off       = pc[2 +: W];
    assign w_idx       = pc[W+2 +: L];
    assign w_tag       = pc[W+L+2 +: TW];
    assign w_base      = {pc[31:W+2], {(W+2){1'b0}}};
    assign w_unused_pc = ^pc[1:0];

    // During a refill the line being written is addressed by the latched address, not pc.
    assign w_ridx = r_mem_addr[W+2 +: L];
    assign w_rtag = r_mem_addr[W+L+2 +: TW];

    assign w_hit  = (r_state == IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_last = (r_state == REFILL) && mem_valid && (r_word_cnt == LAST_WORD);

    assign ready    = w_hit;
    assign instr    = w_hit ? r_data[w_idx][w_off] : NOP;
    assign mem_req  = (r_state == REFILL);
    assign mem_addr = r_mem_addr;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!w_hit) w_state_nxt = REFILL;
            REFILL:  if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= '0;
            r_pend_inv <= 1'b0;
            r_mem_addr <= '0;
            r_word_cnt <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Clearing here and setting the refilled bit later keeps a fresh fill valid.
                    if (invalidate) r_valid <= '0;
                    if (w_hit) begin
                        r_hit_cnt <= sat_inc(r_hit_cnt);
                    end else begin
                        r_mem_addr <= w_base;
                        r_word_cnt <= '0;
                        r_miss_cnt <= sat_inc(r_miss_cnt);
                    end
                end
                REFILL: begin
                    if (w_last) begin
                        if (invalidate || r_pend_inv) begin
                            r_valid <= '0;
                        end else begin
                            r_valid[w_ridx] <= 1'b1;
                        end
                        r_pend_inv <= 1'b0;
                    end else begin
                        if (invalidate) r_pend_inv <= 1'b1;
                        if (mem_valid) begin
                            r_word_cnt <= r_word_cnt + W'(1);
                            r_mem_addr <= r_mem_addr + 32'd4;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (r_state == REFILL && mem_valid) begin
            r_data[w_ridx][r_word_cnt] <= mem_rdata;
        end
        if (w_last) begin
            r_tag[w_ridx] <= w_rtag;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache: the bench plays the backing memory and predicts
// hits, refill addresses, data and counters from a line-level cache model.
module tb_icache;

    localparam int LINES = 16;
    localparam int WORDS = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] LINE_BYTES = 32'(WORDS * 4);

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        invalidate;
    logic [31:0] instr;
    logic        ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    bit          mv [LINES];
    int          mt [LINES];
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    icache #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .invalidate(invalidate),
        .instr     (instr),
        .ready     (ready),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'((a / LINE_BYTES) % 32'(LINES));
    endfunction

    function automatic int tag_of(input logic [31:0] a);
        return int'(a / (LINE_BYTES * 32'(LINES)));
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (w >= 32'h100 && w < 32'h110) return 32'hA0 + (w - 32'h100) / 4;
        return (w * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    endfunction

    // Called at a falling edge; returns at a falling edge. A miss consumes the
    // miss cycle plus every refill cycle; the following fetch sees the result.
    // max_wait < 0 forces exactly -max_wait wait cycles before each word.
    task automatic fetch(input logic [31:0] a, input int max_wait,
                         input bit inv_idle, input int inv_ref);
        int          idx;
        int          tg;
        int          waits;
        int          cyc;
        bit          exp_hit;
        bit          pend;
        logic [31:0] base;
        idx  = line_of(a);
        tg   = tag_of(a);
        base = a - (a % LINE_BYTES);
        pc = a;
        invalidate = inv_idle;
        mem_valid = 1'b0;
        mem_rdata = $urandom;
        #1;
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_misses);
        exp_hit = mv[idx] && (mt[idx] == tg);
        chk("ready", 32'(ready), 32'(exp_hit));
        chk("instr", instr, exp_hit ? mem_word(a) : NOP);
        chk("mem_req_idle", 32'(mem_req), 32'd0);
        if (inv_idle) model_clear();
        if (exp_hit) begin
            m_hits++;
            @(negedge clk);
            invalidate = 1'b0;
            return;
        end
        m_misses++;
        pend = 1'b0;
        @(negedge clk);
        invalidate = 1'b0;
        cyc = 0;
        for (int w = 0; w < WORDS; w++) begin
            waits = (max_wait < 0) ? -max_wait : int'($urandom_range(0, max_wait));
            for (int k = 0; k <= waits; k++) begin
                mem_valid  = (k == waits);
                mem_rdata  = mem_valid ? mem_word(base + 32'(4 * w)) : $urandom;
                invalidate = (cyc == inv_ref);
                if (invalidate) pend = 1'b1;
                pc = $urandom;
                #1;
                chk("mem_req", 32'(mem_req), 32'd1);
                chk("mem_addr", mem_addr, base + 32'(4 * w));
                chk("ready_refill", 32'(ready), 32'd0);
                @(negedge clk);
                cyc++;
            end
        end
        mem_valid  = 1'b0;
        invalidate = 1'b0;
        pc = a;
        mv[idx] = 1'b1;
        mt[idx] = tg;
        if (pend) model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        rst = 1'b0;
        pc = 32'h100;
        invalidate = 1'b0;
        mem_rdata = '0;
        mem_valid = 1'b0;
        model_clear();
        m_hits = '0;
        m_misses = '0;
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // cold miss then hits across the line
        fetch(32'h100, 0, 1'b0, -1);
        fetch(32'h100, 0, 1'b0, -1);
        fetch(32'h104, 0, 1'b0, -1);
        fetch(32'h108, 0, 1'b0, -1);
        fetch(32'h10C, 0, 1'b0, -1);
        // conflict eviction on index 0
        fetch(32'h200, 0, 1'b0, -1);
        fetch(32'h100, 0, 1'b0, -1);
        fetch(32'h108, 0, 1'b0, -1);
        // two wait cycles before every word
        fetch(32'h400, -2, 1'b0, -1);
        fetch(32'h404, 0, 1'b0, -1);
        // invalidate in the second refill cycle
        fetch(32'h200, 0, 1'b0, -1);
        fetch(32'h100, 0, 1'b0, 1);
        fetch(32'h100, 0, 1'b0, -1);
        fetch(32'h10C, 0, 1'b0, -1);
        // invalidate on a hit, then on a miss
        fetch(32'h104, 0, 1'b1, -1);
        fetch(32'h104, 0, 1'b0, -1);
        fetch(32'h600, 1, 1'b1, -1);
        fetch(32'h604, 0, 1'b0, -1);
        // invalidate on the edge that accepts the last word
        fetch(32'h700, 0, 1'b0, 3);
        fetch(32'h700, 0, 1'b0, -1);

        for (int n = 0; n < 300; n++) begin
            a = 32'($urandom_range(0, 3)) * LINE_BYTES * 32'(LINES)
              + 32'($urandom_range(0, LINES - 1)) * LINE_BYTES
              + 32'($urandom_range(0, WORDS - 1)) * 32'd4
              + 32'($urandom_range(0, 3));
            fetch(a, int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        // reset after two refill words
        pc = 32'h7300;
        invalidate = 1'b0;
        mem_valid = 1'b0;
        #1;
        chk("rr_ready_pre", 32'(ready), 32'd0);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            mem_valid = 1'b1;
            mem_rdata = mem_word(32'h7300 + 32'(4 * w));
            @(negedge clk);
        end
        mem_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rr_mem_req", 32'(mem_req), 32'd0);
        chk("rr_mem_addr", mem_addr, 32'd0);
        chk("rr_hit_cnt", hit_cnt, 32'd0);
        chk("rr_miss_cnt", miss_cnt, 32'd0);
        chk("rr_ready", 32'(ready), 32'd0);
        model_clear();
        m_hits = '0;
        m_misses = '0;
        @(negedge clk);
        rst = 1'b1;
        fetch(32'h7300, 0, 1'b0, -1);
        fetch(32'h7308, 0, 1'b0, -1);
        #1;
        chk("final_hit_cnt", hit_cnt, m_hits);
        chk("final_miss_cnt", miss_cnt, m_misses);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipeline's IF stage and a slower backing instruction memory. It answers the IF-stage fetch address with `instr` and the `ready` qualifier that the pipeline already uses to stall PC advance. On a miss it refills one whole line from the backing memory over a req/valid handshake, then serves the hit. It also provides hit/miss counters for debug.

## Interface
- `LINES`, 16: number of cache lines; power of two, at least 2.
- `WORDS`, 4: 32-bit words per line; power of two, at least 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `pc` input 32: fetch byte address from the IF stage; bits [1:0] are ignored.
- `invalidate` input 1: one-cycle request to clear every valid bit (fence.i / program reload).
- `instr` output 32: fetched instruction; valid only while `ready`=1.
- `ready` output 1: `instr` corresponds to the current `pc`.
- `mem_req` output 1: refill word request to the backing memory.
- `mem_addr` output 32: word-aligned refill address; stable while `mem_req`=1.
- `mem_rdata` input 32: refill data from the backing memory.
- `mem_valid` input 1: `mem_rdata` is valid for the current `mem_addr`.
- `hit_cnt` output 32: saturating count of hit cycles.
- `miss_cnt` output 32: saturating count of misses.

## Operation
- Address split, with W=log2(WORDS) and L=log2(LINES):
  - word offset `pc[W+1:2]`
  - index `pc[W+L+1:W+2]`
  - tag `pc[31:W+L+2]`
- Storage: `valid[LINES]`, `tag[LINES]`, `data[LINES][WORDS]`, all registers. Lookup is combinational.
- `hit` = `valid[idx]` && `tag[idx]`==pc tag && state==IDLE.
- `ready`=`hit`. When `ready`=0, `instr`=32'h00000013 (NOP).
- FSM states: IDLE and REFILL.
- IDLE, hit: stay in IDLE; `hit_cnt`+1.
- IDLE, miss: go to REFILL; latch the line base (`pc` with bits [W+1:0] cleared); `mem_req`=1; `mem_addr`=line base; `word_cnt`=0; `miss_cnt`+1.
- REFILL, on an edge with `mem_valid`=1:
  - write `data[idx][word_cnt]`=`mem_rdata`.
  - If `word_cnt`<WORDS-1: increment `word_cnt` and add 4 to `mem_addr`; `mem_req` stays 1.
  - If `word_cnt`==WORDS-1: set `tag[idx]` and `valid[idx]`=1; `mem_req`=0; go to IDLE.
- REFILL, `mem_valid`=0: hold all state; `mem_req` and `mem_addr` stay unchanged.
- Changing `pc` during REFILL: the latched line still completes. Lookup then resumes with the current `pc`, which may miss again.
- `invalidate` in IDLE: all `valid` are cleared on that edge; `ready` is 0 in the following cycle.
- `invalidate` during REFILL: recorded as pending. When the refill completes, all `valid` are cleared, including the just-filled line, and the pending flag is cleared.
- `invalidate` together with a miss in IDLE: clear first, then start the refill; the refilled line is valid afterwards.
- Counters saturate at 32'hFFFFFFFF.

## Timing
- Reset state:
  - state=IDLE; all `valid`=0; pending invalidate=0
  - `mem_req`=0; `mem_addr`=0; `word_cnt`=0
  - `hit_cnt`=0; `miss_cnt`=0
  - `ready`=0; `instr`=32'h00000013
- Tag and data arrays are not reset.
- Hit latency: 0 cycles; `ready`/`instr` follow `pc` in the same cycle.
- Miss with zero-wait memory (`mem_valid` tied high):
  - miss seen in cycle 0
  - `mem_req` high in cycles 1..WORDS
  - `ready`=1 in cycle WORDS+1 (cycle 5 at defaults)
- Each wait cycle on `mem_valid` adds one cycle.
- Handshake rules: `mem_valid` may assert in the first cycle `mem_req` is high. It is ignored while `mem_req`=0. `mem_req` never drops before the last word is accepted.
- Reset asserted mid-refill: immediate return to the reset state; the partially filled line stays invalid.

## Test plan
- Cold miss: reset, `pc`=0x00000100, memory returns 0xA0+i for word i with zero wait. Required: `mem_addr` 0x100, 0x104, 0x108, 0x10C on consecutive cycles; `ready` rises in cycle 5; `instr`=0xA0; `miss_cnt`=1.
- Hits in the same line: after the cold miss, `pc`=0x104, 0x108, 0x10C on consecutive cycles. Required: `ready`=1 every cycle; `instr`=0xA1, 0xA2, 0xA3; `hit_cnt` +3; `mem_req` stays 0.
- Conflict eviction (defaults): fill 0x100, then fetch 0x200 (same index, different tag). Required: refill at 0x200; then `pc`=0x100 misses again; `miss_cnt`=3.
- Wait states: `mem_valid` high only every third cycle. Required: `mem_addr` is held until accepted; `ready` rises in cycle 13 after the miss; data is correct.
- Invalidate during refill: pulse `invalidate` in the second REFILL cycle. Required: the refill completes; the line is invalid afterwards; the next fetch of 0x100 misses.
- Reset mid-refill: assert `rst`=0 after two words. Required: `mem_req`=0 and counters 0 immediately; a fetch of 0x100 after release refills from word 0.
